// File: rtl/alu_cmd_sequencer.sv
// Issue stage in front of the 4-bit ALU: registers operands and selects,
// captures the selected ALU result with flags one cycle later.
module alu_cmd_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic             cmd_chain,
  output logic             alu_s0,
  output logic             alu_s1,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic             alu_c1,
  input  logic             alu_c2,
  input  logic             alu_c3,
  input  logic [3:0]       alu_s,
  input  logic             alu_ca,
  input  logic [3:0]       alu_ss,
  input  logic             alu_cas,
  input  logic [3:0]       alu_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_val,
  output logic             res_cout,
  output logic [2:0]       res_cmp,
  output logic             res_zero,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic       accept;
  logic       capture;
  logic [3:0] last_val;

  logic       op_add;
  logic       op_sub;
  logic       op_cmp;
  logic       op_and;

  logic [3:0] cap_val;
  logic       cap_cout;
  logic [2:0] cap_cmp;
  logic       cap_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    capture   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        cmd_ready = res_ready;
        if (res_ready) begin
          state_nxt = cmd_valid ? ISSUE : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept    = cmd_valid & cmd_ready;
  assign res_valid = (state == DONE);

  assign op_add = ({alu_s1, alu_s0} == 2'b00);
  assign op_sub = ({alu_s1, alu_s0} == 2'b01);
  assign op_cmp = ({alu_s1, alu_s0} == 2'b10);
  assign op_and = ({alu_s1, alu_s0} == 2'b11);

  // Compare reports zero from the ALU's eq line, not from the value.
  always_comb begin
    cap_val  = 4'b0000;
    cap_cout = 1'b0;
    cap_cmp  = 3'b000;
    cap_zero = 1'b0;
    unique case (1'b1)
      op_add: begin
        cap_val  = alu_s;
        cap_cout = alu_ca;
        cap_zero = (alu_s == 4'b0000);
      end
      op_sub: begin
        cap_val  = alu_ss;
        cap_cout = alu_cas;
        cap_zero = (alu_ss == 4'b0000);
      end
      op_cmp: begin
        cap_cmp  = {alu_c1, alu_c2, alu_c3};
        cap_zero = alu_c2;
      end
      op_and: begin
        cap_val  = alu_r;
        cap_zero = (alu_r == 4'b0000);
      end
      default: begin
        cap_val = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_s0 <= 1'b0;
      alu_s1 <= 1'b0;
      alu_a  <= 4'b0000;
      alu_b  <= 4'b0000;
    end else if (accept) begin
      alu_s0 <= cmd_op[0];
      alu_s1 <= cmd_op[1];
      alu_b  <= cmd_b;
      alu_a  <= cmd_chain ? last_val : cmd_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_val  <= 4'b0000;
      res_cout <= 1'b0;
      res_cmp  <= 3'b000;
      res_zero <= 1'b0;
      last_val <= 4'b0000;
      op_count <= '0;
    end else if (capture) begin
      res_val  <= cap_val;
      res_cout <= cap_cout;
      res_cmp  <= cap_cmp;
      res_zero <= cap_zero;
      last_val <= cap_val;
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised self-checking bench for alu_cmd_sequencer with a
// behavioural ALU stub and an arithmetic reference model.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       cmd_chain;
  logic       alu_s0;
  logic       alu_s1;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_c1;
  logic       alu_c2;
  logic       alu_c3;
  logic [3:0] alu_s;
  logic       alu_ca;
  logic [3:0] alu_ss;
  logic       alu_cas;
  logic [3:0] alu_r;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_val;
  logic       res_cout;
  logic [2:0] res_cmp;
  logic       res_zero;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [3:0] mdl_last;
  logic [7:0] mdl_cnt;
  logic [8:0] exp_res;
  logic [3:0] exp_alu_a;
  logic [3:0] obs_alu_a;
  logic [3:0] obs_alu_b;
  logic [1:0] obs_sel;
  logic       obs_ready;
  logic [8:0] obs_res;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_chain(cmd_chain),
    .alu_s0(alu_s0), .alu_s1(alu_s1),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_c1(alu_c1), .alu_c2(alu_c2), .alu_c3(alu_c3),
    .alu_s(alu_s), .alu_ca(alu_ca),
    .alu_ss(alu_ss), .alu_cas(alu_cas),
    .alu_r(alu_r),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_val(res_val), .res_cout(res_cout),
    .res_cmp(res_cmp), .res_zero(res_zero),
    .op_count(op_count)
  );

  // Combinational stand-in for the external 4-bit ALU.
  logic [4:0] add5;
  assign add5    = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_s   = add5[3:0];
  assign alu_ca  = add5[4];
  assign alu_ss  = alu_a - alu_b;
  assign alu_cas = (alu_a >= alu_b);
  assign alu_c1  = (alu_a > alu_b);
  assign alu_c2  = (alu_a == alu_b);
  assign alu_c3  = (alu_a < alu_b);
  assign alu_r   = alu_a & alu_b;

  assign obs_res = {res_val, res_cout, res_cmp, res_zero};

  // Expected {val, cout, cmp, zero} from the operation's arithmetic meaning.
  function automatic logic [8:0] ref_res(
    input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int v;
    case (op)
      2'd0: begin
        v = int'(a) + int'(b);
        return {v[3:0], v >= 16, 3'b000, v[3:0] == 0};
      end
      2'd1: begin
        v = (int'(a) - int'(b) + 16) % 16;
        return {v[3:0], a >= b, 3'b000, v == 0};
      end
      2'd2: return {4'd0, 1'b0, a > b, a == b, a < b, a == b};
      default: begin
        v = int'(a & b);
        return {v[3:0], 1'b0, 3'b000, v == 0};
      end
    endcase
  endfunction

  task automatic model_reset();
    mdl_last = 4'd0;
    mdl_cnt  = 8'd0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue from IDLE (bb=0) or back-to-back from DONE (bb=1).
  task automatic send(input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic chain,
                      input logic bb);
    logic [3:0] ae;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_chain = chain;
    res_ready = bb;
    #1 obs_ready = cmd_ready;
    ae = chain ? mdl_last : a;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    obs_alu_a = alu_a;
    obs_alu_b = alu_b;
    obs_sel   = {alu_s1, alu_s0};
    exp_alu_a = ae;
    exp_res   = ref_res(op, ae, b);
    @(posedge clk);
    #1;
    mdl_last = exp_res[8:5];
    mdl_cnt  = mdl_cnt + 8'd1;
  endtask

  task automatic retire();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_a = 4'd0;
    cmd_b = 4'd0;
    cmd_chain = 1'b0;
    res_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({alu_s0, alu_s1, alu_a, alu_b, res_valid, obs_res, op_count}
        !== '0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got val=%h cnt=%0d rdy=%b, need 0/0/1",
               res_val, op_count, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    send(2'd0, 4'b1111, 4'b1111, 1'b0, 1'b0);
    checks++;
    if (obs_res !== 9'b1110_1_000_0 || res_valid !== 1'b1 ||
        op_count !== 8'd1) begin
      errors++;
      $display("FAIL add_ffff: got res=%b v=%b cnt=%0d, need %b 1 1",
               obs_res, res_valid, op_count, 9'b1110_1_000_0);
    end
    checks++;
    if (obs_alu_a !== 4'hf || obs_alu_b !== 4'hf || obs_sel !== 2'b00) begin
      errors++;
      $display("FAIL add_drive: got a=%h b=%h sel=%b, need f f 00",
               obs_alu_a, obs_alu_b, obs_sel);
    end
    retire();
  endtask

  task automatic test_sub();
    send(2'd1, 4'b1000, 4'b0111, 1'b0, 1'b0);
    checks++;
    if (obs_res !== 9'b0001_1_000_0) begin
      errors++;
      $display("FAIL sub_8_7: got %b, need %b", obs_res, 9'b0001_1_000_0);
    end
    send(2'd1, 4'b0011, 4'b0011, 1'b0, 1'b1);
    checks++;
    if (obs_res !== 9'b0000_1_000_1 || op_count !== mdl_cnt) begin
      errors++;
      $display("FAIL sub_3_3: got %b cnt=%0d, need %b cnt=%0d",
               obs_res, op_count, 9'b0000_1_000_1, mdl_cnt);
    end
    retire();
  endtask

  task automatic test_compare();
    send(2'd2, 4'b1010, 4'b0110, 1'b0, 1'b0);
    checks++;
    if (obs_res !== 9'b0000_0_100_0) begin
      errors++;
      $display("FAIL cmp_gt: got %b, need %b", obs_res, 9'b0000_0_100_0);
    end
    retire();
    send(2'd2, 4'b0101, 4'b0101, 1'b0, 1'b0);
    checks++;
    if (obs_res !== 9'b0000_0_010_1) begin
      errors++;
      $display("FAIL cmp_eq: got %b, need %b", obs_res, 9'b0000_0_010_1);
    end
    retire();
  endtask

  task automatic test_chain();
    send(2'd0, 4'b0011, 4'b0100, 1'b0, 1'b0);
    checks++;
    if (res_val !== 4'b0111) begin
      errors++;
      $display("FAIL chain_add: got %b, need 0111", res_val);
    end
    send(2'd3, 4'b1000, 4'b0101, 1'b1, 1'b1);
    checks++;
    if (obs_ready !== 1'b1 || obs_alu_a !== 4'b0111) begin
      errors++;
      $display("FAIL chain_accept: got rdy=%b a=%b, need 1 0111",
               obs_ready, obs_alu_a);
    end
    checks++;
    if (res_val !== 4'b0101 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL chain_and: got %b v=%b, need 0101 1",
               res_val, res_valid);
    end
    retire();
  endtask

  task automatic test_backpressure();
    logic [8:0] held;
    send(2'd0, 4'd9, 4'd3, 1'b0, 1'b0);
    held = obs_res;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      res_ready = 1'b0;
      cmd_op = 2'($urandom);
      cmd_a = 4'($urandom);
      cmd_b = 4'($urandom);
      #1;
      checks++;
      if (cmd_ready !== 1'b0 || obs_res !== exp_res || held !== exp_res ||
          res_valid !== 1'b1 || alu_a !== 4'd9 || op_count !== mdl_cnt) begin
        errors++;
        $display("FAIL bp_hold%0d: got rdy=%b res=%b a=%h, need 0 %b 9",
                 i, cmd_ready, obs_res, alu_a, exp_res);
      end
    end
    cmd_valid = 1'b0;
    retire();
    #1;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== mdl_cnt) begin
      errors++;
      $display("FAIL bp_release: got v=%b rdy=%b cnt=%0d, need 0 1 %0d",
               res_valid, cmd_ready, op_count, mdl_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_a = 4'd1;
    cmd_b = 4'd1;
    cmd_chain = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_reset();
    #1;
    checks++;
    if (res_valid !== 1'b0 || op_count !== 8'd0 || cmd_ready !== 1'b1 ||
        alu_a !== 4'd0) begin
      errors++;
      $display("FAIL rst_issue: got v=%b cnt=%0d rdy=%b, need 0 0 1",
               res_valid, op_count, cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_issue_after: got v=%b cnt=%0d, need 0 0",
               res_valid, op_count);
    end
    send(2'd0, 4'd3, 4'd4, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (res_valid !== 1'b0 || obs_res !== 9'd0 || op_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_done: got v=%b res=%b cnt=%0d, need 0 0 0",
               res_valid, obs_res, op_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(2'd0, 4'd9, 4'd2, 1'b1, 1'b0);
    checks++;
    if (obs_alu_a !== 4'd0 || res_val !== 4'd2) begin
      errors++;
      $display("FAIL rst_last_val: got a=%h val=%h, need 0 2",
               obs_alu_a, res_val);
    end
    retire();
  endtask

  task automatic test_random();
    logic in_done;
    logic bb;
    in_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      bb = in_done && ($urandom_range(0, 1) == 1);
      if (in_done && !bb) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        retire();
      end
      send(2'($urandom), 4'($urandom), 4'($urandom),
           $urandom_range(0, 2) == 0, bb);
      in_done = 1'b1;
      checks++;
      if (obs_res !== exp_res || obs_alu_a !== exp_alu_a ||
          res_valid !== 1'b1 || op_count !== mdl_cnt) begin
        errors++;
        $display("FAIL rand%0d: got res=%b a=%h cnt=%0d, need %b %h %0d",
                 i, obs_res, obs_alu_a, op_count, exp_res, exp_alu_a,
                 mdl_cnt);
      end
    end
    retire();
  endtask

  task automatic test_wrap();
    hard_reset();
    for (int i = 0; i < 256; i++) begin
      send(2'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
      if (i == 254) begin
        checks++;
        if (op_count !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: got %0d, need 255", op_count);
        end
      end
      retire();
    end
    checks++;
    if (op_count !== 8'd0 || mdl_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: got %0d, need 0", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_compare();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
